conv_puncturer: RTL and testbench
=================================

Name: conv_puncturer

Overview:
- Sits directly downstream of the rate-1/2, K=7 convolutional encoder in the 802.11a TX chain, and upstream of the bit interleaver.
- Accepts one coded pair (A,B) per handshake and deletes bits according to the frame's coding rate (1/2, 2/3 or 3/4).
- Serialises the surviving bits onto a single-bit valid/ready stream and counts the output bits of the frame.

Parameters:
- CNT_W, 16, width of the per-frame output bit counter.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iStart  in  1  frame-start pulse; honoured only in IDLE.
- iRate  in  2  rate code, latched on iStart: 0=1/2, 1=2/3, 2=3/4, 3=reserved (treated as 1/2).
- iDataA  in  1  encoder output A.
- iDataB  in  1  encoder output B.
- iValid  in  1  input pair valid.
- iLast  in  1  marks the final pair of the frame; qualified by iValid.
- oInReady  out  1  block can accept a pair this cycle.
- oData  out  1  serial punctured bit.
- oValid  out  1  oData valid.
- iReady  in  1  downstream accepts oData.
- oLast  out  1  high with the final output bit of the frame.
- oBitCount  out  CNT_W  output bits transferred in the current frame.
- oBusy  out  1  high while in state RUN.

Behaviour:
- Reset values: all outputs 0; state IDLE; hold register empty; phase 0; latched rate 1/2.
- States: IDLE, RUN.
  - IDLE→RUN on iStart. This latches iRate, clears phase and oBitCount, and clears the last-held flag.
  - RUN→IDLE in the cycle after the oLast bit transfers.
  - iStart in RUN is ignored.
- Puncture patterns, indexed by phase; keep mask {keepA, keepB}:
  - 1/2: period 1. Phase 0 = {1,1}.
  - 2/3: period 2. Phase 0 = {1,1}; phase 1 = {1,0}.
  - 3/4: period 3. Phase 0 = {1,1}; phase 1 = {1,0}; phase 2 = {0,1}.
- Input acceptance:
  - A pair transfers when iValid && oInReady.
  - On transfer, the block stores hA and hB, loads the mask for the current phase, and advances phase modulo the period (wrap to 0).
  - If iLast was set, the block sets the last-held flag.
- Hold register output:
  - oValid = (mask != 0).
  - oData = hA while keepA is set, otherwise hB. A is always emitted before B.
  - Each output transfer (oValid && iReady) clears the emitted mask bit.
- oInReady = RUN && !lastHeld && (mask==0 || (transfer this cycle && exactly one mask bit set)).
  - This gives zero-bubble back-to-back operation.
  - Ready depends combinationally on iReady. No combinational path exists from iValid to oValid.
- Latency: an accepted pair's first kept bit is on oData in the following cycle.
- Throughput with iReady held high:
  - 1/2: one pair every 2 cycles.
  - 2/3: 2 pairs per 3 cycles.
  - 3/4: 3 pairs per 4 cycles.
- oLast = oValid && lastHeld && exactly one mask bit set.
- A frame may end mid-period. No padding is inserted; phase resets at the next iStart.
- oBitCount:
  - Increments on each output transfer.
  - Saturates at all-ones.
  - Holds its value in IDLE until the next iStart.
- Input pairs presented while in IDLE are not accepted (oInReady=0).
- iValid dropping mid-frame simply stalls the block; phase holds.
- Reset asserted mid-frame returns the block to IDLE immediately. The held pair is discarded and oValid drops asynchronously.

Decomposition:
- Shared package conv_pkg:
  - Rate codes RATE_1_2/RATE_2_3/RATE_3_4.
  - State encoding IDLE/RUN.
  - Period constants 1/2/3.
  - Puncture mask constants.
- One natural sub-module, punct_pattern: combinational, (rate, phase) → keep mask and period.
- The handshake, hold register and counter stay in conv_puncturer.

Test Plan:
- Rate 1/2, pairs (1,0),(0,1),(1,1) with iLast on the third, iReady=1 → oData 1,0,0,1,1,1; oLast on the 6th bit; oBitCount=6; oInReady pattern 1,0,1,0,1.
- Rate 2/3, pairs (1,1),(0,1),(1,0),(1,1) with iLast on the fourth → oData 1,1,0,1,0,1; pair-1 and pair-3 B bits dropped; oBitCount=6.
- Rate 3/4, pairs (1,0),(1,1),(0,1) with iLast → oData 1,0,1,1; oLast on the 4th bit; then back to IDLE with oBusy=0.
- Backpressure: rate 3/4, iReady toggled 1,0,0,1,… → no bits lost or duplicated; output matches the 3/4 golden sequence; phase wraps correctly over 6 pairs.
- iRate=3 → behaves exactly as 1/2. iStart asserted during RUN → ignored, latched rate unchanged.
- iRst pulsed after the second pair of a 3/4 frame → oValid=0, oBitCount=0, IDLE. A new iStart at rate 2/3 starts from phase 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional-code puncturer: rate codes, FSM states,
// puncture periods and keep masks.
package conv_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'd0,
    RATE_2_3  = 2'd1,
    RATE_3_4  = 2'd2,
    RATE_RSVD = 2'd3
  } rate_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] PERIOD_1_2 = 2'd1;
  localparam logic [1:0] PERIOD_2_3 = 2'd2;
  localparam logic [1:0] PERIOD_3_4 = 2'd3;

  // Keep masks are {keepA, keepB}
  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_B    = 2'b01;
  localparam logic [1:0] MASK_A    = 2'b10;
  localparam logic [1:0] MASK_AB   = 2'b11;

endpackage

// File: rtl/punct_pattern.sv
// Puncture pattern lookup: maps (rate, phase) to the {keepA, keepB} mask and the
// pattern period. The reserved rate code falls back to rate 1/2.
module punct_pattern
  import conv_pkg::*;
(
  input  rate_t      rate,
  input  logic [1:0] phase,
  output logic [1:0] mask,
  output logic [1:0] period
);

  always_comb begin
    mask   = MASK_AB;
    period = PERIOD_1_2;
    case (rate)
      RATE_2_3: begin
        period = PERIOD_2_3;
        mask   = (phase == 2'd1) ? MASK_A : MASK_AB;
      end
      RATE_3_4: begin
        period = PERIOD_3_4;
        case (phase)
          2'd1:    mask = MASK_A;
          2'd2:    mask = MASK_B;
          default: mask = MASK_AB;
        endcase
      end
      default: begin
        mask   = MASK_AB;
        period = PERIOD_1_2;
      end
    endcase
  end

endmodule

// File: rtl/conv_puncturer.sv
// Punctures rate-1/2 encoder pairs down to 1/2, 2/3 or 3/4 and serialises the
// surviving bits onto a single-bit valid/ready stream with a per-frame bit count.
//
//   state | meaning
//   IDLE  | waiting for iStart; pairs refused, bit count holds last frame's total
//   RUN   | accepting pairs and emitting kept bits until the oLast bit transfers
module conv_puncturer
  import conv_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [1:0]       iRate,
  input  logic             iDataA,
  input  logic             iDataB,
  input  logic             iValid,
  input  logic             iLast,
  output logic             oInReady,
  output logic             oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oLast,
  output logic [CNT_W-1:0] oBitCount,
  output logic             oBusy
);

  state_t           state;
  rate_t            rate;
  logic [1:0]       phase;
  logic [1:0]       mask;
  logic [1:0]       pat_mask;
  logic [1:0]       period;
  logic             h_a;
  logic             h_b;
  logic             last_held;
  logic [CNT_W-1:0] bit_count;
  logic             out_xfer;
  logic             in_xfer;
  logic             one_left;

  punct_pattern u_pattern (
    .rate   (rate),
    .phase  (phase),
    .mask   (pat_mask),
    .period (period)
  );

  assign one_left  = (mask == MASK_A) || (mask == MASK_B);
  assign oValid    = (mask != MASK_NONE);
  assign oData     = mask[1] ? h_a : h_b;
  assign out_xfer  = oValid && iReady;
  // Refill in the same cycle the final held bit leaves, so pairs stream without bubbles
  assign oInReady  = (state == RUN) && !last_held &&
                     ((mask == MASK_NONE) || (out_xfer && one_left));
  assign in_xfer   = iValid && oInReady;
  assign oLast     = oValid && last_held && one_left;
  assign oBitCount = bit_count;
  assign oBusy     = (state == RUN);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      rate      <= RATE_1_2;
      phase     <= 2'd0;
      mask      <= MASK_NONE;
      h_a       <= 1'b0;
      h_b       <= 1'b0;
      last_held <= 1'b0;
      bit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state     <= RUN;
            rate      <= rate_t'(iRate);
            phase     <= 2'd0;
            mask      <= MASK_NONE;
            last_held <= 1'b0;
            bit_count <= '0;
          end
        end
        RUN: begin
          if (out_xfer) begin
            if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
            mask <= mask[1] ? (mask & MASK_B) : MASK_NONE;
            if (oLast) state <= IDLE;
          end
          // A new pair only lands when the hold register is (becoming) empty
          if (in_xfer) begin
            h_a   <= iDataA;
            h_b   <= iDataB;
            mask  <= pat_mask;
            phase <= (phase == period - 2'd1) ? 2'd0 : phase + 2'd1;
            if (iLast) last_held <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_puncturer.sv
// Self-checking bench for conv_puncturer: directed and randomized frames checked
// against a pattern-table reference model of the puncturing rules.
module tb_conv_puncturer;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic             iStart = 1'b0;
  logic [1:0]       iRate = 2'd0;
  logic             iDataA = 1'b0;
  logic             iDataB = 1'b0;
  logic             iValid = 1'b0;
  logic             iLast = 1'b0;
  logic             iReady = 1'b0;
  logic             oInReady;
  logic             oData;
  logic             oValid;
  logic             oLast;
  logic [CNT_W-1:0] oBitCount;
  logic             oBusy;

  int checks = 0;
  int passed = 0;

  logic pa[$];
  logic pb[$];
  logic got[$];
  logic rtrace[$];

  conv_puncturer #(.CNT_W(CNT_W)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iRate     (iRate),
    .iDataA    (iDataA),
    .iDataB    (iDataB),
    .iValid    (iValid),
    .iLast     (iLast),
    .oInReady  (oInReady),
    .oData     (oData),
    .oValid    (oValid),
    .iReady    (iReady),
    .oLast     (oLast),
    .oBitCount (oBitCount),
    .oBusy     (oBusy)
  );

  always #5 iClk = ~iClk;

  // Runs one frame of the pairs in pa/pb; rdy_mode 0=always ready, 1=1,0,0 pattern, 2=random
  task automatic run_frame(input logic [1:0] rate, input int rdy_mode, input bit vld_rand,
                           input bit start_mid, input logic [15:0] gold, input int gold_n,
                           input string name);
    logic exp_bits[$];
    int   period, ph, n, in_idx, last_pos, exp_cnt;
    bit   done, ok;
    n      = pa.size();
    period = (rate == 2'd3) ? 1 : int'(rate) + 1;
    for (int i = 0; i < n; i++) begin
      ph = i % period;
      if (ph != 2) exp_bits.push_back(pa[i]);
      if (ph != 1) exp_bits.push_back(pb[i]);
    end
    exp_cnt = (exp_bits.size() > CNT_MAX) ? CNT_MAX : exp_bits.size();
    got.delete();
    rtrace.delete();
    in_idx   = 0;
    last_pos = -1;
    done     = 0;

    @(negedge iClk);
    iStart = 1'b1;
    iRate  = rate;
    @(negedge iClk);
    iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b1) $display("FAIL %s busy_start got=%0b exp=1", name, oBusy);
    else passed++;

    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      iStart = start_mid && (cyc == 3);
      iRate  = start_mid ? ((rate == 2'd2) ? 2'd1 : 2'd2) : rate;
      iValid = (in_idx < n) && (!vld_rand || ($urandom_range(0, 1) == 1));
      iDataA = (in_idx < n) ? pa[in_idx] : 1'b0;
      iDataB = (in_idx < n) ? pb[in_idx] : 1'b0;
      iLast  = (in_idx == n - 1);
      case (rdy_mode)
        0:       iReady = 1'b1;
        1:       iReady = (cyc % 3 == 0);
        default: iReady = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (in_idx < n) rtrace.push_back(oInReady);
      if (oValid && iReady) begin
        got.push_back(oData);
        if (oLast) begin
          last_pos = got.size();
          done     = 1;
        end
      end
      if (iValid && oInReady) in_idx++;
      @(negedge iClk);
    end
    iValid = 1'b0;
    iLast  = 1'b0;
    iStart = 1'b0;
    iReady = 1'b0;
    #1;

    checks++;
    if (!done) $display("FAIL %s timeout no oLast transfer, bits got=%0d exp=%0d", name, got.size(), exp_bits.size());
    else passed++;

    ok = (got.size() == exp_bits.size());
    for (int i = 0; i < got.size() && ok; i++) if (got[i] !== exp_bits[i]) ok = 0;
    checks++;
    if (!ok) $display("FAIL %s bits got_len=%0d exp_len=%0d (sequence differs)", name, got.size(), exp_bits.size());
    else passed++;

    if (gold_n > 0) begin
      ok = (got.size() == gold_n);
      for (int i = 0; i < got.size() && ok; i++) if (got[i] !== gold[gold_n - 1 - i]) ok = 0;
      checks++;
      if (!ok) $display("FAIL %s golden got_len=%0d exp_len=%0d", name, got.size(), gold_n);
      else passed++;
    end

    checks++;
    if (last_pos != exp_bits.size()) $display("FAIL %s olast_pos got=%0d exp=%0d", name, last_pos, exp_bits.size());
    else passed++;

    checks++;
    if (oBitCount !== exp_cnt[CNT_W-1:0]) $display("FAIL %s bitcount got=%0d exp=%0d", name, oBitCount, exp_cnt);
    else passed++;

    checks++;
    if (oBusy !== 1'b0 || oInReady !== 1'b0) $display("FAIL %s idle_after got busy=%0b inready=%0b exp 0/0", name, oBusy, oInReady);
    else passed++;
  endtask

  task automatic set_pairs(input logic [7:0] a, input logic [7:0] b, input int n);
    logic [7:0] va, vb;
    va = a;
    vb = b;
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(va[n - 1 - i]);
      pb.push_back(vb[n - 1 - i]);
    end
  endtask

  task automatic rand_pairs(input int n);
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(1'($urandom_range(0, 1)));
      pb.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    checks++;
    if (oValid !== 0 || oData !== 0 || oLast !== 0 || oInReady !== 0 || oBusy !== 0 || oBitCount !== 0)
      $display("FAIL reset_values got v=%0b d=%0b l=%0b r=%0b b=%0b c=%0d exp all 0",
               oValid, oData, oLast, oInReady, oBusy, oBitCount);
    else passed++;
    iRst = 1'b0;
    iValid = 1'b1;
    iReady = 1'b1;
    iDataA = 1'b1;
    iDataB = 1'b1;
    repeat (3) begin
      @(negedge iClk);
      #1;
      checks++;
      if (oInReady !== 0 || oValid !== 0 || oBusy !== 0)
        $display("FAIL idle_refuse got inready=%0b valid=%0b busy=%0b exp 0/0/0", oInReady, oValid, oBusy);
      else passed++;
    end
    iValid = 1'b0;
  endtask

  task automatic test_rate_1_2();
    logic [4:0] exp_r;
    logic [4:0] got_r;
    exp_r = 5'b10101;
    set_pairs(8'b101, 8'b011, 3);
    run_frame(2'd0, 0, 0, 0, 16'b100111, 6, "rate12");
    got_r = '0;
    for (int i = 0; i < 5 && i < rtrace.size(); i++) got_r[4 - i] = rtrace[i];
    checks++;
    if (rtrace.size() != 5 || got_r !== exp_r)
      $display("FAIL rate12_inready got=%b len=%0d exp=%b", got_r, rtrace.size(), exp_r);
    else passed++;
  endtask

  task automatic test_rate_2_3();
    set_pairs(8'b1011, 8'b1101, 4);
    run_frame(2'd1, 0, 0, 0, 16'b110101, 6, "rate23");
  endtask

  task automatic test_rate_3_4();
    set_pairs(8'b110, 8'b011, 3);
    run_frame(2'd2, 0, 0, 0, 16'b1011, 4, "rate34");
  endtask

  task automatic test_backpressure();
    rand_pairs(6);
    run_frame(2'd2, 1, 0, 0, 16'b0, 0, "backpressure34");
  endtask

  task automatic test_reserved_rate();
    set_pairs(8'b101, 8'b011, 3);
    run_frame(2'd3, 0, 0, 0, 16'b100111, 6, "rate_rsvd");
    rand_pairs(7);
    run_frame(2'd3, 2, 1, 0, 16'b0, 0, "rate_rsvd_rand");
  endtask

  task automatic test_start_in_run();
    rand_pairs(8);
    run_frame(2'd1, 0, 0, 1, 16'b0, 0, "start_in_run23");
    rand_pairs(8);
    run_frame(2'd0, 0, 0, 1, 16'b0, 0, "start_in_run12");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      rand_pairs($urandom_range(1, 30));
      run_frame(2'($urandom_range(0, 3)), 2, 1, 0, 16'b0, 0, $sformatf("random%0d", f));
    end
  endtask

  task automatic test_reset_midframe();
    int acc;
    acc = 0;
    @(negedge iClk);
    iStart = 1'b1;
    iRate  = 2'd2;
    @(negedge iClk);
    iStart = 1'b0;
    iValid = 1'b1;
    iReady = 1'b1;
    for (int cyc = 0; cyc < 50 && acc < 2; cyc++) begin
      iDataA = 1'($urandom_range(0, 1));
      iDataB = 1'($urandom_range(0, 1));
      #1;
      if (iValid && oInReady) acc++;
      if (acc < 2) @(negedge iClk);
    end
    checks++;
    if (acc != 2) $display("FAIL rst_mid_accept got=%0d exp=2", acc);
    else passed++;
    @(posedge iClk);
    #1;
    checks++;
    if (oValid !== 1'b1 || oBitCount !== 5'd2)
      $display("FAIL rst_mid_pre got valid=%0b cnt=%0d exp 1/2", oValid, oBitCount);
    else passed++;
    iRst = 1'b1;
    #1;
    checks++;
    if (oValid !== 0 || oBitCount !== 0 || oBusy !== 0 || oInReady !== 0)
      $display("FAIL rst_mid_post got valid=%0b cnt=%0d busy=%0b inready=%0b exp 0", oValid, oBitCount, oBusy, oInReady);
    else passed++;
    @(negedge iClk);
    iRst   = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    rand_pairs(5);
    run_frame(2'd1, 0, 0, 0, 16'b0, 0, "after_rst23");
  endtask

  initial begin
    test_reset();
    test_rate_1_2();
    test_rate_2_3();
    test_rate_3_4();
    test_backpressure();
    test_reserved_rate();
    test_start_in_run();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
